// File: rtl/fifo_pop_demux_pkg.sv
// Shared definitions for the FIFO pop / destination demux block.
// Holds the controller state encoding, default field geometry and the
// one-hot destination decode used to build the push strobe.
package fifo_pop_demux_pkg;

   localparam int unsigned DEF_DATA_W    = 6;
   localparam int unsigned DEF_DEST_BITS = 2;
   localparam int unsigned DEF_DEST_LSB  = 4;
   localparam int unsigned DEF_STALL_W   = 8;

   // Widest one-hot vector the decode helper can produce (DEST_BITS <= 4).
   localparam int unsigned MAX_NDEST     = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
   } state_e;

   // One-hot decode of a destination index; callers truncate to NDEST bits.
   function automatic logic [MAX_NDEST-1:0] dest_onehot(input int unsigned idx);
      logic [MAX_NDEST-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_NDEST; i++) begin
         r[i] = (idx == i);
      end
      return r;
   endfunction

endpackage : fifo_pop_demux_pkg

// File: rtl/fifo_pop_demux_stall_counter.sv
// Saturating event counter used to count cycles a word sits blocked.
// Ports:
//   clk  - clock
//   clr  - asynchronous active-high clear
//   inc  - increment enable, sampled on the rising edge
//   cnt  - current count, sticks at all-ones
module stall_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // Count up while enabled, stop at the maximum value.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule : stall_counter

// File: rtl/fifo_pop_demux.sv
// Pops words from an upstream FIFO and routes each one to one of NDEST
// downstream queues selected by a field inside the word. A word whose
// destination is paused is held (never dropped) and the blocked cycles are
// counted.
// Ports:
//   clk, RESET   - clock, asynchronous active-high reset
//   fifo_empty   - upstream empty flag
//   fifo_data    - upstream read data, valid the cycle after fifo_rd
//   err_fifo     - upstream error; suppresses new reads
//   dest_pause   - per-destination almost-full
//   fifo_rd      - pop strobe (combinational)
//   push         - one-hot push strobe (combinational)
//   data_out     - word presented downstream, qualified by push
//   busy         - controller not idle
//   stall_cnt    - saturating count of blocked SEND cycles
module fifo_pop_demux
   import fifo_pop_demux_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned DEST_BITS = DEF_DEST_BITS,
   parameter int unsigned DEST_LSB  = DEF_DEST_LSB,
   parameter int unsigned STALL_W   = DEF_STALL_W,
   localparam int unsigned NDEST    = 2**DEST_BITS
) (
   input  logic               clk,
   input  logic               RESET,
   input  logic               fifo_empty,
   input  logic [DATA_W-1:0]  fifo_data,
   input  logic               err_fifo,
   input  logic [NDEST-1:0]   dest_pause,
   output logic               fifo_rd,
   output logic [NDEST-1:0]   push,
   output logic [DATA_W-1:0]  data_out,
   output logic               busy,
   output logic [STALL_W-1:0] stall_cnt
);

   state_e                 state;
   state_e                 state_nx;
   logic [DATA_W-1:0]      hold;
   logic [DEST_BITS-1:0]   dest;
   logic                   armed;
   logic                   rd_ok;
   logic                   dest_blocked;
   logic                   stall_inc;

   // State register. 'armed' keeps reads off for the first cycle after reset.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         armed <= 1'b0;
      end else begin
         state <= state_nx;
         armed <= 1'b1;
      end
   end

   // Capture the popped word and its destination at the end of FETCH.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         hold <= '0;
         dest <= '0;
      end else if (state == FETCH) begin
         hold <= fifo_data;
         dest <= fifo_data[DEST_LSB +: DEST_BITS];
      end
   end

   assign rd_ok        = armed && !fifo_empty && !err_fifo;
   assign dest_blocked = dest_pause[dest];

   // Next-state and strobe decode.
   always_comb begin
      state_nx  = state;
      fifo_rd   = 1'b0;
      push      = '0;
      stall_inc = 1'b0;
      case (state)
         IDLE: begin
            fifo_rd = rd_ok;
            if (rd_ok) begin
               state_nx = FETCH;
            end
         end
         FETCH: begin
            state_nx = SEND;
         end
         SEND: begin
            if (dest_blocked) begin
               stall_inc = 1'b1;
            end else begin
               push     = NDEST'(dest_onehot(32'(dest)));
               fifo_rd  = rd_ok;
               state_nx = rd_ok ? FETCH : IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign data_out = hold;
   assign busy     = (state != IDLE);

   stall_counter #(
      .W (STALL_W)
   ) u_stall_counter (
      .clk (clk),
      .clr (RESET),
      .inc (stall_inc),
      .cnt (stall_cnt)
   );

endmodule : fifo_pop_demux

// File: tb/tb_fifo_pop_demux.sv
// Directed bench for fifo_pop_demux with a behavioural upstream FIFO
// (read latency 1) and a scoreboard of expected deliveries.
module tb_fifo_pop_demux;

   logic       clk;
   logic       RESET;
   logic       fifo_empty;
   logic [5:0] fifo_data;
   logic       err_fifo;
   logic [3:0] dest_pause;
   logic       fifo_rd;
   logic [3:0] push;
   logic [5:0] data_out;
   logic       busy;
   logic [7:0] stall_cnt;

   int         n_vec;
   int         n_err;
   int         cyc_n;
   int         prev_push_cyc;
   bit         have_prev;
   bit         chk_gap;

   logic       s_rd;
   logic [3:0] s_push;
   logic [5:0] s_data;
   logic       s_busy;

   logic [5:0] fifo_q[$];
   logic [5:0] exp_q[$];

   fifo_pop_demux dut (
      .clk        (clk),
      .RESET      (RESET),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .err_fifo   (err_fifo),
      .dest_pause (dest_pause),
      .fifo_rd    (fifo_rd),
      .push       (push),
      .data_out   (data_out),
      .busy       (busy),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [3:0] onehot4(input logic [5:0] w);
      logic [1:0] f;
      f = w[5:4];
      return 4'b0001 << f;
   endfunction

   task automatic load(input logic [5:0] w, input bit expect_delivery);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
      if (expect_delivery) exp_q.push_back(w);
   endtask

   // One clock: sample mid-cycle, score any push, then model the FIFO pop.
   task automatic cyc();
      logic [5:0] e;
      @(negedge clk);
      s_rd   = fifo_rd;
      s_push = push;
      s_data = data_out;
      s_busy = busy;
      cyc_n++;
      if (s_rd) chk("rd_while_empty", 32'(fifo_empty), 32'(0));
      if (s_push != 4'b0000) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_push", 32'(s_push), 32'(0));
         end else begin
            e = exp_q.pop_front();
            chk("push_dest", 32'(s_push), 32'(onehot4(e)));
            chk("push_data", 32'(s_data), 32'(e));
            if (chk_gap && have_prev) chk("push_gap", 32'(cyc_n - prev_push_cyc), 32'(2));
            prev_push_cyc = cyc_n;
            have_prev     = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (s_rd && fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic drain(input string tag, input int max_cyc);
      bit done;
      done = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (fifo_q.size() == 0 && exp_q.size() == 0 && !busy) begin
            done = 1'b1;
            break;
         end
         cyc();
      end
      chk({tag, "_timeout"}, 32'(done), 32'(1));
      chk({tag, "_left"}, 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc_n = 0;
      prev_push_cyc = 0; have_prev = 1'b0; chk_gap = 1'b0;
      RESET = 1'b1; fifo_empty = 1'b1; fifo_data = '0;
      err_fifo = 1'b0; dest_pause = '0;

      // Power-on reset values.
      #3;
      chk("por_rd", 32'(fifo_rd), 32'(0));
      chk("por_push", 32'(push), 32'(0));
      chk("por_busy", 32'(busy), 32'(0));
      chk("por_data", 32'(data_out), 32'(0));
      chk("por_stall", 32'(stall_cnt), 32'(0));
      repeat (2) @(posedge clk);
      #1 RESET = 1'b0;
      cyc(); cyc();

      // Reset asserted during FETCH discards the in-flight word.
      load(6'h05, 1'b0);
      load(6'h1A, 1'b1);
      cyc();
      chk("rst_first_rd", 32'(s_rd), 32'(1));
      RESET = 1'b1;
      #1;
      chk("rst_rd", 32'(fifo_rd), 32'(0));
      chk("rst_push", 32'(push), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_data", 32'(data_out), 32'(0));
      cyc();
      chk("rst_hold_rd", 32'(s_rd), 32'(0));
      cyc();
      RESET = 1'b0;
      cyc();
      chk("rst_release_rd", 32'(s_rd), 32'(0));
      drain("rst_resume", 20);

      // Single word to destination 2.
      load(6'h25, 1'b1);
      cyc();
      chk("single_rd", 32'(s_rd), 32'(1));
      chk("single_idle", 32'(s_busy), 32'(0));
      cyc();
      chk("single_fetch_rd", 32'(s_rd), 32'(0));
      chk("single_fetch_busy", 32'(s_busy), 32'(1));
      cyc();
      chk("single_push", 32'(s_push), 32'(4'b0100));
      chk("single_busy_low", 32'(busy), 32'(0));

      // Burst routing at full rate.
      chk_gap = 1'b1; have_prev = 1'b0;
      load(6'h01, 1'b1); load(6'h12, 1'b1); load(6'h23, 1'b1);
      load(6'h34, 1'b1); load(6'h3F, 1'b1);
      drain("burst", 30);
      chk_gap = 1'b0;

      // Backpressure on destination 1 for 10 cycles.
      chk("bp_stall0", 32'(stall_cnt), 32'(0));
      dest_pause = 4'b0010;
      load(6'h1C, 1'b1);
      load(6'h30, 1'b1);
      cyc(); cyc();
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("bp_push", 32'(s_push), 32'(0));
         chk("bp_rd", 32'(s_rd), 32'(0));
      end
      chk("bp_stall10", 32'(stall_cnt), 32'(10));
      dest_pause = 4'b0000;
      cyc();
      chk("bp_release_push", 32'(s_push), 32'(4'b0010));
      chk("bp_release_rd", 32'(s_rd), 32'(1));
      drain("bp", 20);
      chk("bp_stall_after", 32'(stall_cnt), 32'(10));

      // Pause on other destinations is ignored.
      dest_pause = 4'b1101;
      load(6'h10, 1'b1);
      cyc(); cyc(); cyc();
      chk("other_push", 32'(s_push), 32'(4'b0010));
      drain("other", 10);
      chk("other_stall", 32'(stall_cnt), 32'(10));
      dest_pause = 4'b0000;

      // err_fifo raised during FETCH: word delivered, then no pops.
      load(6'h08, 1'b1); load(6'h15, 1'b1); load(6'h2A, 1'b1);
      cyc();
      chk("err_first_rd", 32'(s_rd), 32'(1));
      err_fifo = 1'b1;
      cyc();
      cyc();
      chk("err_push", 32'(s_push), 32'(4'b0001));
      chk("err_send_rd", 32'(s_rd), 32'(0));
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("err_blocked_rd", 32'(s_rd), 32'(0));
         chk("err_idle", 32'(s_busy), 32'(0));
      end
      chk("err_fifo_level", 32'(fifo_q.size()), 32'(2));
      err_fifo = 1'b0;
      drain("err_resume", 20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fifo_pop_demux

// File: doc/fifo_pop_demux.md
Name: fifo_pop_demux

Overview:
- Downstream consumer of the 6-bit `fifo` block.
- Pops words from the FIFO whenever it is non-empty.
- Decodes a destination field from each word and pushes the word to one of NDEST downstream queues.
- Holds a word while its destination signals pause (almost-full), so no word is ever dropped; counts stall cycles for debug.

Parameters:
- DATA_W, 6: word width; matches the `fifo` data path.
- DEST_BITS, 2: width of the destination field; NDEST = 2**DEST_BITS = 4.
- DEST_LSB, 4: LSB position of the destination field within the word, i.e. field = word[DEST_LSB+DEST_BITS-1:DEST_LSB] = word[5:4].
- STALL_W, 8: width of the saturating stall counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  upstream FIFO empty flag.
- fifo_data  in  DATA_W  upstream FIFO `data_out`; valid the cycle after `fifo_rd` is high.
- err_fifo  in  1  upstream FIFO error; while high, no new reads are issued.
- dest_pause  in  NDEST  per-destination almost-full; bit i high blocks pushes to destination i.
- fifo_rd  out  1  pop strobe to the upstream FIFO.
- push  out  NDEST  one-hot push strobe to the downstream queues.
- data_out  out  DATA_W  word presented to the downstream queues; qualified by `push`.
- busy  out  1  high whenever state != IDLE.
- stall_cnt  out  STALL_W  saturating count of cycles spent blocked in SEND.

Behaviour:
- Reset (asynchronous, RESET=1):
  - state=IDLE, hold register=0, data_out=0, stall_cnt=0.
  - fifo_rd=0, push=0, busy=0 while RESET is asserted and on the first cycle after release.
- Upstream read latency is 1: a word requested with fifo_rd in cycle N is sampled from fifo_data at the rising edge ending cycle N+1.
- State machine, 3 states:
  - IDLE:
    - fifo_rd = !fifo_empty && !err_fifo.
    - If fifo_rd is high, go to FETCH; otherwise stay in IDLE.
  - FETCH:
    - fifo_rd=0.
    - At the edge: hold <= fifo_data; dest <= hold-field of fifo_data; go to SEND.
  - SEND:
    - data_out = hold.
    - If !dest_pause[dest]:
      - push = one-hot(dest) this cycle.
      - fifo_rd = !fifo_empty && !err_fifo.
      - Next state is FETCH if fifo_rd is high, else IDLE.
    - If dest_pause[dest]:
      - push=0, fifo_rd=0, stay in SEND.
      - stall_cnt increments, saturating at 2**STALL_W-1.
- fifo_rd and push are combinational from the state and the inputs. data_out is driven from the hold register and holds its last value when push=0.
- Throughput: one word every 2 cycles at best (SEND -> FETCH -> SEND).
- Invariants:
  - fifo_rd is never high while fifo_empty=1.
  - At most one push bit is high per cycle.
  - Every popped word is pushed exactly once, in FIFO order.
- err_fifo asserting mid-operation: a word already in FETCH or SEND is still delivered; no further pops; after delivery the block returns to IDLE and stays there until err_fifo drops.
- dest_pause changing while in SEND: re-evaluated every cycle; the push fires on the first cycle the destination's pause bit is low.
- Pause bits of other destinations are ignored.
- RESET asserted mid-word: the held word is discarded; state returns to IDLE immediately.
- stall_cnt clears only on reset.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, FETCH=2'd1, SEND=2'd2;
  - DEST_LSB and DEST_BITS defaults;
  - the one-hot decode function.
- Natural sub-module: `stall_counter` (saturating STALL_W-bit counter with increment enable and async active-high clear). Everything else stays in one module.

Test Plan:
- Reset mid-stream: load FIFO with 0x05,0x1A; assert RESET during FETCH -> all outputs 0 and state IDLE immediately; after release, reading resumes with the next FIFO word.
- Single word: push 0x25 (dest 2) into the empty FIFO -> fifo_rd pulses 1 cycle; 2 cycles later push=4'b0100, data_out=0x25; busy returns low.
- Burst routing: FIFO holds 0x01,0x12,0x23,0x34,0x3F -> push sequence 0001,0010,0100,1000,1000 at 2-cycle spacing with matching data; fifo_rd never high with fifo_empty=1.
- Backpressure: word 0x1C (dest 1) with dest_pause=4'b0010 held for 10 cycles -> push=0 and fifo_rd=0 for 10 cycles, stall_cnt=10; pause drops -> push=0010, data_out=0x1C exactly once.
- Other-destination pause: dest_pause=4'b1101 while delivering 0x10 (dest 1) -> delivered without stalling; stall_cnt unchanged.
- err_fifo: raise err_fifo during FETCH of 0x08 -> 0x08 is delivered to dest 0, then no fifo_rd while the FIFO is non-empty; err_fifo drops -> pops resume in order.
